// File: rtl/rectangle128_keysched_if.sv
// Key-schedule bus between the RECTANGLE128 round core and its key feeder.
// Carries start/key load, round-key read address/data and status.
interface rectangle128_keysched_if #(
  parameter int AW = 5
);
  logic          Start;
  logic [127:0]  masterKey;
  logic [AW-1:0] RAddr;
  logic [63:0]   roundKey;
  logic          skey_ready;
  logic          busy;

  modport master (
    output Start, masterKey, RAddr,
    input  roundKey, skey_ready, busy
  );

  modport slave (
    input  Start, masterKey, RAddr,
    output roundKey, skey_ready, busy
  );
endinterface

// File: rtl/rectangle128_keysched.sv
// RECTANGLE128 key expansion: 128-bit master key -> 26 x 64-bit round keys.
// Optional macro RECTANGLE128_KEY_ZEROIZE_EN clears key material after use.
module rectangle128_keysched #(
  parameter int NUM_RK = 26,
  parameter int AW     = 5
) (
  input logic Clk,
  input logic Rst,
  rectangle128_keysched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [4:0]    rc_q, rc_d;
  logic [127:0]  key_q, key_d;
  logic [63:0]   rk_q [NUM_RK];
  logic [63:0]   rk_d [NUM_RK];
  logic          skey_ready_q, skey_ready_d;
  logic          busy_q, busy_d;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'h6;
      4'h1: y = 4'h5;
      4'h2: y = 4'hC;
      4'h3: y = 4'hA;
      4'h4: y = 4'h1;
      4'h5: y = 4'hE;
      4'h6: y = 4'h7;
      4'h7: y = 4'h9;
      4'h8: y = 4'hB;
      4'h9: y = 4'h0;
      4'hA: y = 4'h3;
      4'hB: y = 4'hD;
      4'hC: y = 4'h8;
      4'hD: y = 4'hF;
      4'hE: y = 4'h4;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // One key-state round: S-box on low 8 columns, row mix, rc injection.
  function automatic logic [127:0] key_update(
    input logic [127:0] k,
    input logic [4:0]   rc
  );
    logic [31:0] r0, r1, r2, r3;
    logic [31:0] n0, n3;
    logic [3:0]  s;
    r0 = k[31:0];
    r1 = k[63:32];
    r2 = k[95:64];
    r3 = k[127:96];
    for (int j = 0; j < 8; j++) begin
      s = sbox({r3[j], r2[j], r1[j], r0[j]});
      r0[j] = s[0];
      r1[j] = s[1];
      r2[j] = s[2];
      r3[j] = s[3];
    end
    n0 = {r0[23:0], r0[31:24]} ^ r1;
    n0[4:0] = n0[4:0] ^ rc;
    n3 = {r3[15:0], r3[31:16]} ^ r0;
    return {n3, r3, r2, n0};
  endfunction

  // Next-state logic for the FSM, key state and round-key file.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rc_d         = rc_q;
    key_d        = key_q;
    rk_d         = rk_q;
    skey_ready_d = skey_ready_q;
    busy_d       = busy_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
`ifdef RECTANGLE128_KEY_ZEROIZE_EN
          if (state_q == DONE) begin
            for (int i = 0; i < NUM_RK; i++) begin
              rk_d[i] = '0;
            end
          end
`endif
          key_d        = bus.masterKey;
          cnt_d        = '0;
          rc_d         = 5'h01;
          skey_ready_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = EXPAND;
        end
      end
      EXPAND: begin
        rk_d[cnt_q] = {key_q[111:96], key_q[79:64],
                       key_q[47:32], key_q[15:0]};
        key_d = key_update(key_q, rc_q);
        rc_d  = {rc_q[3:0], rc_q[4] ^ rc_q[2]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NUM_RK - 1)) begin
`ifdef RECTANGLE128_KEY_ZEROIZE_EN
          key_d = '0;
          rc_d  = '0;
`endif
          skey_ready_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rc_q         <= 5'h01;
      key_q        <= '0;
      skey_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < NUM_RK; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rc_q         <= rc_d;
      key_q        <= key_d;
      skey_ready_q <= skey_ready_d;
      busy_q       <= busy_d;
      rk_q         <= rk_d;
    end
  end

  // Zero-latency read; addresses past the last key return zero.
  always_comb begin
    bus.roundKey = '0;
    if (bus.RAddr < AW'(NUM_RK)) begin
      bus.roundKey = rk_q[bus.RAddr];
    end
  end

  assign bus.skey_ready = skey_ready_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_rectangle128_keysched.sv
// Bench for rectangle128_keysched: reference schedule model with a
// scoreboard queue, constant vectors, restart/abort sequences.
module tb_rectangle128_keysched;

  logic Clk = 1'b0;
  logic Rst;

  rectangle128_keysched_if bus ();

  rectangle128_keysched dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  localparam logic [63:0] SBOX_TAB = 64'h24F8_D30B_97E1_AC56;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb [$];
  logic [63:0] last_rk1;

  typedef struct {
    logic [127:0] key;
    logic [4:0]   addr;
    logic [63:0]  exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model_step(input logic [127:0] k,
                                              input logic [4:0] rc);
    logic [31:0] r [4];
    logic [63:0] tab;
    logic [3:0]  n;
    logic [3:0]  s;
    tab = SBOX_TAB;
    for (int i = 0; i < 4; i++) r[i] = k[32*i +: 32];
    for (int j = 0; j < 8; j++) begin
      n = {r[3][j], r[2][j], r[1][j], r[0][j]};
      s = tab[4*n +: 4];
      for (int i = 0; i < 4; i++) r[i][j] = s[i];
    end
    return {{r[3][15:0], r[3][31:16]} ^ r[0],
            r[3], r[2],
            ({r[0][23:0], r[0][31:24]} ^ r[1]) ^ {27'd0, rc}};
  endfunction

  function automatic void push_schedule(input logic [127:0] key);
    logic [127:0] k;
    logic [4:0]   rc;
    k  = key;
    rc = 5'h01;
    for (int i = 0; i < 26; i++) begin
      sb.push_back({k[111:96], k[79:64], k[47:32], k[15:0]});
      k  = model_step(k, rc);
      rc = {rc[3:0], rc[4] ^ rc[2]};
    end
  endfunction

  task automatic do_start(input logic [127:0] key);
    @(negedge Clk);
    bus.Start     = 1'b1;
    bus.masterKey = key;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    push_schedule(key);
  endtask

  task automatic run_expand(input string tag, input bit glitch);
    int n_done;
    int busy_bad;
    n_done   = -1;
    busy_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      if (glitch && (n == 5 || n == 12)) begin
        bus.Start     = 1'b1;
        bus.masterKey = ~bus.masterKey;
      end
      @(posedge Clk);
      #1;
      bus.Start = 1'b0;
      if (bus.skey_ready) begin
        n_done = n;
        break;
      end
      if (bus.busy !== 1'b1) busy_bad++;
    end
    chk({tag, "_done_edge"}, 64'(n_done), 64'd26);
    chk({tag, "_busy_gap"}, 64'(busy_bad), 64'd0);
    chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic drain(input string tag);
    logic [63:0] exp;
    for (int a = 0; a < 26; a++) begin
      bus.RAddr = 5'(a);
      #1;
      if (sb.size() == 0) begin
        chk($sformatf("%s_sb_empty%0d", tag, a), 64'd1, 64'd0);
      end else begin
        exp = sb.pop_front();
        if (a == 1) last_rk1 = exp;
        chk($sformatf("%s_rk%0d", tag, a), bus.roundKey, exp);
      end
    end
  endtask

  initial begin
    logic [127:0] rk;
    bus.Start     = 1'b0;
    bus.masterKey = '0;
    bus.RAddr     = '0;
    last_rk1      = '0;

    tbl[0] = '{128'h0, 5'd0, 64'h0};
    tbl[1] = '{128'h0, 5'd1, 64'h0000_0000_00FF_00FE};
    tbl[2] = '{128'h0, 5'd26, 64'h0};
    tbl[3] = '{128'h0, 5'd31, 64'h0};
    tbl[4] = '{{128{1'b1}}, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[5] = '{{128{1'b1}}, 5'd1, 64'h00FF_FF00_FF00_FF01};
    tbl[6] = '{{128{1'b1}}, 5'd30, 64'h0};
    tbl[7] = '{{128{1'b1}}, 5'd26, 64'h0};

    Rst = 1'b1;
    #2;
    chk("rst_ready", 64'(bus.skey_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_rk0", bus.roundKey, 64'h0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (i == 0 || tbl[i].key !== tbl[i-1].key) begin
        do_start(tbl[i].key);
        run_expand($sformatf("vec%0d", i), 1'b0);
        drain($sformatf("vec%0d", i));
      end
      bus.RAddr = tbl[i].addr;
      #1;
      chk($sformatf("tbl%0d", i), bus.roundKey, tbl[i].exp);
    end

    rk = {$urandom, $urandom, $urandom, $urandom};
    do_start(rk);
    run_expand("rand", 1'b0);
    drain("rand");
    bus.RAddr = 5'd26;
    #1;
    chk("rand_a26", bus.roundKey, 64'h0);
    bus.RAddr = 5'd31;
    #1;
    chk("rand_a31", bus.roundKey, 64'h0);

    rk = {$urandom, $urandom, $urandom, $urandom};
    do_start(rk);
    run_expand("glitch", 1'b1);
    drain("glitch");

    rk = {$urandom, $urandom, $urandom, $urandom};
    do_start(rk);
    chk("restart_ready", 64'(bus.skey_ready), 64'd0);
    chk("restart_busy", 64'(bus.busy), 64'd1);
    bus.RAddr = 5'd1;
    #1;
`ifdef RECTANGLE128_KEY_ZEROIZE_EN
    chk("restart_rk1", bus.roundKey, 64'h0);
`else
    chk("restart_rk1", bus.roundKey, last_rk1);
`endif
    run_expand("restart", 1'b0);
    drain("restart");

    rk = {$urandom, $urandom, $urandom, $urandom};
    do_start(rk);
    repeat (10) @(posedge Clk);
    #1;
    chk("abort_busy_pre", 64'(bus.busy), 64'd1);
    bus.RAddr = 5'd0;
    #1;
    chk("abort_rk0_pre", bus.roundKey, sb[0]);
    sb.delete();
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    chk("abort_ready", 64'(bus.skey_ready), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_rk0", bus.roundKey, 64'h0);
    for (int a = 0; a < 32; a++) begin
      bus.RAddr = 5'(a);
      #1;
      chk($sformatf("abort_a%0d", a), bus.roundKey, 64'h0);
    end
    @(negedge Clk);
    Rst = 1'b0;

    rk = {$urandom, $urandom, $urandom, $urandom};
    do_start(rk);
    run_expand("post_rst", 1'b0);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
